aes_encipher_block: RTL
=======================

# aes_encipher_block

Iterative AES encipher datapath and control, parametrised in S-box throughput and supporting both AES-128 and AES-256 round counts. It runs a complete block encryption from one `next` pulse: the initial AddRoundKey, SubBytes through module-external S-boxes, and the main and final rounds. It sits between the key memory, which supplies the round key for the round index it outputs, and the shared S-box bank. It replaces per-round sequencing in the core top level.

## Interface
Parameters:
- SBOX_LANES, default 1: 32-bit words substituted per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- next  in  1  start pulse; honoured only while ready=1.
- keylen  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); sampled with next.
- block  in  128  plaintext; sampled with next.
- round  out  4  index of the round key needed this cycle.
- round_key  in  128  key for `round`; must be valid combinationally in the same cycle.
- sboxw  out  32*SBOX_LANES  words sent to the S-boxes; lane i is bits [32i+31:32i].
- new_sboxw  in  32*SBOX_LANES  substituted words, returned combinationally.
- new_block  out  128  state registers; holds the ciphertext while ready=1.
- ready  out  1  idle / result valid.

## Operation
- State: four 32-bit words w0..w3. w0 = bits [127:96]. Within each word, byte [31:24] is row 0.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE: ready=1. When next=1, latch keylen and block, clear ready, go to INIT.
- INIT: round=0; state <= block ^ round_key; round_ctr <= 1; sword_ctr <= 0; go to SBOX.
- SBOX: round=round_ctr.
  - Lane i presents word sword_ctr*SBOX_LANES+i on sboxw and writes back new_sboxw into that word.
  - sword_ctr counts modulo 4/SBOX_LANES.
  - After the last group, go to MAIN.
- MAIN: round=round_ctr.
  - If round_ctr < NR: state <= AddRoundKey(MixColumns(ShiftRows(state))); round_ctr++; sword_ctr <= 0; go to SBOX.
  - If round_ctr == NR: state <= AddRoundKey(ShiftRows(state)) with no MixColumns; set ready; go to IDLE.
- NR = 10 or 14, taken from the latched keylen.
- GF(2^8) arithmetic:
  - gm2(x) = {x[6:0],0} ^ (0x1b if x[7]).
  - gm3(x) = gm2(x) ^ x.
  - MixColumns uses only first-stage (ShiftRows) bytes as inputs.
- sboxw = 0 outside SBOX.
- round is 0 in IDLE.

## Timing
- Reset values: state = 0, round = 0, sboxw = 0, new_block = 0, ready = 1, FSM = IDLE, both counters = 0.
- Latency from the next edge to ready=1 is 1 + NR*(4/SBOX_LANES + 1) cycles. Examples:
  - AES-128, SBOX_LANES=1: 51 cycles.
  - AES-128, SBOX_LANES=4: 21 cycles.
  - AES-256, SBOX_LANES=1: 71 cycles.
- ready falls on the cycle after next is accepted.
- next while busy is ignored. Changes to keylen or block while busy have no effect.
- next in the same cycle that ready rises is ignored; a new operation needs next with ready=1 already registered.
- new_block is stable from ready rising until the next accepted start.
- reset_n low at any point, including mid-operation, aborts the operation and restores the reset values on the next edge.

## Configuration
- AES_ENC_KEYLEN256_EN
  - Defined: keylen is honoured, NR is 10 or 14, and round spans 0..14.
  - Undefined: keylen is ignored, NR is fixed at 10, the AES-256 comparison logic is removed, and round never exceeds 10.

## Structure
- Package aes_pkg holds:
  - gm2 and gm3 functions;
  - AES128_ROUNDS=10 and AES256_ROUNDS=14;
  - FSM state encoding;
  - key-length constants.
- One combinational sub-module, aes_enc_round_comb, with inputs state, round_key and a final flag, and output next_state (ShiftRows, optional MixColumns, AddRoundKey).
- FSM, counters and registers live in the top module.

## Test plan
- FIPS-197 C.1: AES-128, key 000102…0f, pt 00112233445566778899aabbccddeeff; bench key model drives round_key from round. Expect new_block = 69c4e0d86a7b0430d8cdb78070b4c55a, with ready rising exactly 51 cycles after next (SBOX_LANES=1).
- FIPS-197 C.3: AES-256, key 000102…1f, same pt. Expect 8ea2b7ca516745bfeafc49904b496089 after 71 cycles; with macro undefined, keylen=1 still yields the C.1 ciphertext.
- SBOX_LANES=2 and SBOX_LANES=4 rerun C.1: same ciphertext, in 31 and 21 cycles. Check sboxw lane ordering against the bench S-box model each cycle.
- next pulsed every cycle during an operation with a different block: result and latency unchanged; after ready, a fresh next starts a new operation.
- Assert reset_n low at cycle 20 of an operation: next cycle ready=1, new_block=0, round=0; a subsequent C.1 run is correct.
- Back-to-back: pt 0 then pt ffff…ff with next issued the cycle after ready rises. Both ciphertexts match the reference model, and the first remains on new_block until the second next.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the iterative AES encipher block:
//   - GF(2^8) helpers gm2/gm3 used by MixColumns
//   - round counts for AES-128 and AES-256
//   - key-length encodings for the keylen input
//   - FSM state encoding of the encipher controller
// Optional feature macro used by the design: AES_ENC_KEYLEN256_EN.
package aes_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int AES256_ROUNDS = 14;

    localparam logic AES_KEYLEN_128 = 1'b0;
    localparam logic AES_KEYLEN_256 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_SBOX,
        ST_MAIN
    } aes_enc_state_e;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] x);
        return gm2(x) ^ x;
    endfunction

endpackage

// File: rtl/aes_enc_round_comb.sv
// aes_enc_round_comb
// Combinational tail of one AES round: ShiftRows, optional MixColumns and
// AddRoundKey. SubBytes has already been applied to i_state by the caller.
// Ports:
//   i_state      in  128  state after SubBytes (w0 = [127:96], row 0 = MSB byte)
//   i_round_key  in  128  round key to add
//   i_final      in  1    last round: skip MixColumns
//   o_next_state out 128  resulting state
module aes_enc_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_final,
    output logic [127:0] o_next_state
);

    logic [127:0] w_shifted;
    logic [127:0] w_mixed;

    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gm2(a0) ^ gm3(a1) ^ a2      ^ a3,
                a0      ^ gm2(a1) ^ gm3(a2) ^ a3,
                a0      ^ a1      ^ gm2(a2) ^ gm3(a3),
                gm3(a0) ^ a1      ^ a2      ^ gm2(a3)};
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    always_comb begin
        w_shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shifted[127 - 32*c - 8*r -: 8] = i_state[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
    end

    // MixColumns is fed purely from the ShiftRows output.
    always_comb begin
        w_mixed = '0;
        for (int c = 0; c < 4; c++) begin
            w_mixed[127 - 32*c -: 32] = mixColumn(w_shifted[127 - 32*c -: 32]);
        end
    end

    assign o_next_state = (i_final ? w_shifted : w_mixed) ^ i_round_key;

endmodule

// File: rtl/aes_encipher_block.sv
// aes_encipher_block
// Iterative AES encipher: one next pulse runs the initial AddRoundKey, then
// per round SubBytes (through external S-boxes, SBOX_LANES words per cycle)
// followed by ShiftRows/MixColumns/AddRoundKey.
// Parameter: SBOX_LANES (1, 2 or 4) words substituted per cycle.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   next           start pulse, honoured while ready=1
//   keylen         0 = AES-128, 1 = AES-256 (sampled with next)
//   block          plaintext (sampled with next)
//   round          round key index needed this cycle
//   round_key      round key for `round`, combinational from key memory
//   sboxw          words to the S-box bank, lane i = [32i+31:32i]
//   new_sboxw      substituted words from the S-box bank
//   new_block      state register, ciphertext while ready=1
//   ready          idle / result valid
// Macro AES_ENC_KEYLEN256_EN: when defined keylen selects 10 or 14 rounds,
// otherwise keylen is ignored and 10 rounds are always used.
module aes_encipher_block
    import aes_pkg::*;
#(
    parameter int SBOX_LANES = 1
)
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       next,
    input  logic                       keylen,
    input  logic [127:0]               block,
    output logic [3:0]                 round,
    input  logic [127:0]               round_key,
    output logic [32*SBOX_LANES-1:0]   sboxw,
    input  logic [32*SBOX_LANES-1:0]   new_sboxw,
    output logic [127:0]               new_block,
    output logic                       ready
);

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_badLanes
        $error("aes_encipher_block: SBOX_LANES must be 1, 2 or 4");
    end

    localparam logic [1:0] LAST_GROUP = 2'(4 / SBOX_LANES - 1);

    aes_enc_state_e          r_fsm;
    aes_enc_state_e          w_fsmNext;
    logic [127:0]            r_state;
    logic [127:0]            r_plain;
    logic [3:0]              r_roundCtr;
    logic [1:0]              r_swordCtr;
    logic                    r_ready;
    logic [3:0]              w_numRounds;
    logic                    w_isFinal;
    logic [127:0]            w_subState;
    logic [127:0]            w_roundOut;
    logic [32*SBOX_LANES-1:0] w_laneWords;

`ifdef AES_ENC_KEYLEN256_EN
    logic r_keylen;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_keylen <= AES_KEYLEN_128;
        end else if (r_fsm == ST_IDLE && next) begin
            r_keylen <= keylen;
        end
    end

    assign w_numRounds = (r_keylen == AES_KEYLEN_256) ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);
`else
    logic w_unusedKeylen;
    assign w_unusedKeylen = keylen;
    assign w_numRounds    = 4'(AES128_ROUNDS);
`endif

    assign w_isFinal = (r_roundCtr == w_numRounds);
    assign new_block = r_state;
    assign ready     = r_ready;

    // Words of the current group go out to the S-boxes; the substituted
    // words are merged back into an otherwise unchanged copy of the state.
    always_comb begin
        w_laneWords = '0;
        w_subState  = r_state;
        for (int i = 0; i < SBOX_LANES; i++) begin
            w_laneWords[32*i +: 32] = r_state[127 - 32*(int'(r_swordCtr)*SBOX_LANES + i) -: 32];
            w_subState[127 - 32*(int'(r_swordCtr)*SBOX_LANES + i) -: 32] = new_sboxw[32*i +: 32];
        end
    end

    aes_enc_round_comb u_roundComb (
        .i_state      (r_state),
        .i_round_key  (round_key),
        .i_final      (w_isFinal),
        .o_next_state (w_roundOut)
    );

    // Next-state and output decode; round and sboxw default to zero so the
    // key memory and S-box bank see quiet inputs outside their phases.
    always_comb begin
        w_fsmNext = r_fsm;
        round     = 4'd0;
        sboxw     = '0;
        case (r_fsm)
            ST_IDLE: begin
                if (next) begin
                    w_fsmNext = ST_INIT;
                end
            end
            ST_INIT: begin
                w_fsmNext = ST_SBOX;
            end
            ST_SBOX: begin
                round = r_roundCtr;
                sboxw = w_laneWords;
                if (r_swordCtr == LAST_GROUP) begin
                    w_fsmNext = ST_MAIN;
                end
            end
            ST_MAIN: begin
                round     = r_roundCtr;
                w_fsmNext = w_isFinal ? ST_IDLE : ST_SBOX;
            end
            default: w_fsmNext = ST_IDLE;
        endcase
    end

    // State register, counters and the ready flag. ready is only set on the
    // final round, so a next arriving on that same edge finds the FSM still
    // in MAIN and is ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fsm      <= ST_IDLE;
            r_state    <= '0;
            r_plain    <= '0;
            r_roundCtr <= 4'd0;
            r_swordCtr <= 2'd0;
            r_ready    <= 1'b1;
        end else begin
            r_fsm <= w_fsmNext;
            case (r_fsm)
                ST_IDLE: begin
                    if (next) begin
                        r_plain <= block;
                        r_ready <= 1'b0;
                    end
                end
                ST_INIT: begin
                    r_state    <= r_plain ^ round_key;
                    r_roundCtr <= 4'd1;
                    r_swordCtr <= 2'd0;
                end
                ST_SBOX: begin
                    r_state    <= w_subState;
                    r_swordCtr <= (r_swordCtr == LAST_GROUP) ? 2'd0 : r_swordCtr + 2'd1;
                end
                ST_MAIN: begin
                    r_state <= w_roundOut;
                    if (w_isFinal) begin
                        r_ready <= 1'b1;
                    end else begin
                        r_roundCtr <= r_roundCtr + 4'd1;
                        r_swordCtr <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
